bc_frame_serializer: RTL and testbench
======================================

// Module: bc_frame_serializer
// PURPOSE
// - Parametrised successor to the 4-bit number-to-barcode converter.
// - Accepts a word of DIGITS 4-bit digits on a valid/ready handshake.
// - Encodes each digit to an 11-bit bar pattern and adds an optional mod-16 check digit.
// - Emits the frame one bar per cycle, wrapped in start/stop guards, under out_ready backpressure.
// - Sits between the numeric datapath and the barcode output driver / VCD-observed sink.
// PARAMETERS
// - DIGITS    default 4  number of data digits per frame (>=1)
// - CHECK_EN  default 1  1 = append check digit = (sum of data digits) mod 16; 0 = no check digit
// - GAP       default 2  idle cycles (bc_valid=0) forced after each frame; 0 allowed
// PORTS
// - clk        in   1         single clock, all state on rising edge
// - rst        in   1         synchronous reset, active-high
// - in_valid   in   1         in_num holds a frame request
// - in_ready   out  1         block can accept a frame this cycle
// - in_num     in   4*DIGITS  digits; digit 0 (sent first) = in_num[4*DIGITS-1 -: 4]
// - out_ready  in   1         sink consumes bc_bit this cycle
// - bc_valid   out  1         bc_bit is a frame bar
// - bc_bit     out  1         current bar (1 = bar, 0 = space)
// - bc_sof     out  1         first bar of frame (first start-guard bit)
// - bc_eof     out  1         last bar of frame (last stop-guard bit)
// - busy       out  1         high in any state other than IDLE
// BEHAVIOUR
// - Digit code, d[3:0] -> 11 bits, MSB first: {1,0, d3,~d3, d2,~d2, d1,~d1, d0,~d0, 0}.
//   - 0 -> 10010101010; 5 -> 10011001100; A -> 10100110010; F -> 10101010100.
// - Frame = START "101" + DIGITS codes (+ check code if CHECK_EN) + STOP "101".
//   - Length L = 6 + 11*(DIGITS+CHECK_EN); 61 at defaults.
// - Check digit: 4-bit wrap-around sum of the data digits, carry discarded.
// - FSM states: IDLE -> START -> DATA -> [CHECK] -> STOP -> GAP -> IDLE.
//   - GAP=0 skips GAP; STOP goes straight to IDLE.
// - Input handshake:
//   - in_ready = 1 only in IDLE with rst low.
//   - Transfer occurs on an edge with in_valid & in_ready; in_num is latched and the FSM enters START.
//   - First bar (bc_valid=1, bc_sof=1) appears the cycle after the transfer edge.
//   - in_num and in_valid are ignored while busy.
// - Output handshake:
//   - A bar is consumed on any edge with bc_valid & out_ready; the next bar appears the following cycle.
//   - With out_ready low, bc_bit/bc_sof/bc_eof/bc_valid hold; no timeout.
//   - Consuming the bar with bc_eof moves the FSM to GAP (or IDLE if GAP=0).
// - GAP counts GAP cycles independent of out_ready.
// - bc_sof and bc_eof are only high together with bc_valid; never high together because L > 1.
// - bc_bit = 0 whenever bc_valid = 0.
// - Bar/digit counters are internal and sized for L; no wrap inside a frame.
// - Reset (any state, incl. mid-frame):
//   - Next state IDLE; the frame is abandoned, not resumed.
//   - bc_valid=0, bc_bit=0, bc_sof=0, bc_eof=0, busy=0, in_ready=0 while rst=1.
//   - in_ready=1 the first cycle after rst falls.
// - Back-to-back: with GAP=0 and in_valid held, a new frame is accepted the cycle after IDLE is re-entered.
//   - Minimum frame-to-frame period is L+1+GAP cycles.
// TESTING
// - Reset: hold rst 3 cycles -> all outputs 0; first cycle after release -> in_ready=1, busy=0.
// - Defaults, in_num=16'h05AF, out_ready=1:
//   - 61 bars = 101 + codes(0,5,A,F) + code(E)=10101010010 + 101.
//   - sof on bar 1, eof on bar 61, then 2 cycles with bc_valid=0, then in_ready=1.
// - Backpressure: same frame, out_ready toggled randomly -> identical bar sequence; outputs stable while out_ready=0.
// - CHECK_EN=0, DIGITS=1, GAP=0, in_num=4'h0, in_valid held:
//   - 17-bar frames 101 10010101010 101 repeating every 18 cycles.
// - Reset mid-frame: rst after bar 20 -> bc_valid=0 next cycle.
//   - New frame after release starts with sof and "101"; no leftover bars.
// - Ignore-while-busy: change in_num/in_valid during a frame -> frame bits unchanged; no second frame until in_ready.

Source files
------------

// File: rtl/bc_frame_serializer.sv
// bc_frame_serializer: latches a word of 4-bit digits, then emits a barcode
// frame one bar per cycle: start guard "101", one 11-bit code per digit,
// an optional mod-16 check-digit code, stop guard "101", then GAP idle cycles.
// Output bars follow a valid/ready handshake. A bar holds until it is consumed.
module bc_frame_serializer #(
    parameter int DIGITS   = 4,
    parameter int CHECK_EN = 1,
    parameter int GAP      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   in_num,
    input  logic                  out_ready,
    output logic                  bc_valid,
    output logic                  bc_bit,
    output logic                  bc_sof,
    output logic                  bc_eof,
    output logic                  busy
);

    // The digit counter only has to reach DIGITS-1.
    // The gap counter only has to reach GAP-1.
    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [DW-1:0] DIGIT_LAST = DW'(DIGITS - 1);
    localparam logic [GW-1:0] GAP_LAST   = GW'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_CHECK,
        S_STOP,
        S_GAP
    } state_t;

    state_t                 state_reg, state_next;
    logic [3:0]             bit_cnt_reg, bit_cnt_next;      // bar index inside a guard or code
    logic [DW-1:0]          digit_cnt_reg, digit_cnt_next;  // data digit being sent
    logic [4*DIGITS-1:0]    num_reg, num_next;              // remaining digits, current one at top
    logic [3:0]             check_reg, check_next;
    logic [GW-1:0]          gap_cnt_reg, gap_cnt_next;

    logic                   frame_valid;
    logic                   frame_bit;
    logic                   frame_sof;
    logic                   frame_eof;
    logic [3:0]             cur_digit;
    logic [10:0]            cur_code;
    logic [3:0]             in_sum;
    logic [3:0]             in_digit [DIGITS];

    // Digit gi of the incoming word. Digit 0 is the most significant nibble.
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign in_digit[gi] = in_num[4*(DIGITS-gi)-1 -: 4];
        end
    endgenerate

    // Check digit: 4-bit wrap-around sum of the data digits. Carries are dropped.
    always_comb begin
        in_sum = '0;
        for (int i = 0; i < DIGITS; i++) begin
            in_sum = in_sum + in_digit[i];
        end
    end

    // Bar code of a digit, MSB first: 1,0 then each bit with its complement, then 0.
    function automatic logic [10:0] bar_code(input logic [3:0] d);
        return {2'b10, d[3], ~d[3], d[2], ~d[2], d[1], ~d[1], d[0], ~d[0], 1'b0};
    endfunction

    // The digit being coded comes from the top of the shifted digit register.
    // In CHECK it comes from the latched check digit instead.
    always_comb begin
        cur_digit = (state_reg == S_CHECK) ? check_reg : num_reg[4*DIGITS-1 -: 4];
        cur_code  = bar_code(cur_digit);
    end

    // State and datapath registers, with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            bit_cnt_reg   <= '0;
            digit_cnt_reg <= '0;
            num_reg       <= '0;
            check_reg     <= '0;
            gap_cnt_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            bit_cnt_reg   <= bit_cnt_next;
            digit_cnt_reg <= digit_cnt_next;
            num_reg       <= num_next;
            check_reg     <= check_next;
            gap_cnt_reg   <= gap_cnt_next;
        end
    end

    // Next-state logic and the current bar.
    // Bar counters advance only when a bar is consumed.
    always_comb begin
        state_next     = state_reg;
        bit_cnt_next   = bit_cnt_reg;
        digit_cnt_next = digit_cnt_reg;
        num_next       = num_reg;
        check_next     = check_reg;
        gap_cnt_next   = gap_cnt_reg;
        frame_valid    = 1'b0;
        frame_bit      = 1'b0;
        frame_sof      = 1'b0;
        frame_eof      = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (in_valid) begin
                    state_next     = S_START;
                    num_next       = in_num;
                    check_next     = in_sum;
                    bit_cnt_next   = '0;
                    digit_cnt_next = '0;
                end
            end
            S_START: begin
                frame_valid = 1'b1;
                frame_bit   = ~bit_cnt_reg[0];
                frame_sof   = (bit_cnt_reg == 4'd0);
                if (out_ready) begin
                    if (bit_cnt_reg == 4'd2) begin
                        state_next   = S_DATA;
                        bit_cnt_next = '0;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                    end
                end
            end
            S_DATA: begin
                frame_valid = 1'b1;
                frame_bit   = cur_code[4'd10 - bit_cnt_reg];
                if (out_ready) begin
                    if (bit_cnt_reg == 4'd10) begin
                        bit_cnt_next = '0;
                        if (digit_cnt_reg == DIGIT_LAST) begin
                            state_next = (CHECK_EN != 0) ? S_CHECK : S_STOP;
                        end else begin
                            digit_cnt_next = digit_cnt_reg + DW'(1);
                            num_next       = num_reg << 4;
                        end
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                    end
                end
            end
            S_CHECK: begin
                frame_valid = 1'b1;
                frame_bit   = cur_code[4'd10 - bit_cnt_reg];
                if (out_ready) begin
                    if (bit_cnt_reg == 4'd10) begin
                        bit_cnt_next = '0;
                        state_next   = S_STOP;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                    end
                end
            end
            S_STOP: begin
                frame_valid = 1'b1;
                frame_bit   = ~bit_cnt_reg[0];
                frame_eof   = (bit_cnt_reg == 4'd2);
                if (out_ready) begin
                    if (bit_cnt_reg == 4'd2) begin
                        bit_cnt_next = '0;
                        gap_cnt_next = '0;
                        state_next   = (GAP > 0) ? S_GAP : S_IDLE;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt_reg == GAP_LAST) begin
                    state_next = S_IDLE;
                end else begin
                    gap_cnt_next = gap_cnt_reg + GW'(1);
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // All outputs are forced low while reset is asserted.
    // This holds even on the first reset cycle, before the registers clear.
    always_comb begin
        in_ready = ~rst & (state_reg == S_IDLE);
        busy     = ~rst & (state_reg != S_IDLE);
        bc_valid = ~rst & frame_valid;
        bc_bit   = ~rst & frame_bit;
        bc_sof   = ~rst & frame_sof;
        bc_eof   = ~rst & frame_eof;
    end

endmodule

// File: tb/tb_bc_frame_serializer.sv
// Testbench for bc_frame_serializer.
// Instance A uses the default configuration.
// Instance B uses DIGITS=1, CHECK_EN=0, GAP=0.
// Captured bar streams are compared against a frame model built from the barcode rules.
module tb_bc_frame_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Instance A: defaults
    logic        rst_a = 1'b1, in_valid_a = 1'b0, out_ready_a = 1'b0;
    logic [15:0] in_num_a = '0;
    logic        in_ready_a, bc_valid_a, bc_bit_a, bc_sof_a, bc_eof_a, busy_a;

    bc_frame_serializer #(.DIGITS(4), .CHECK_EN(1), .GAP(2)) dut_a (
        .clk(clk), .rst(rst_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .in_num(in_num_a), .out_ready(out_ready_a), .bc_valid(bc_valid_a),
        .bc_bit(bc_bit_a), .bc_sof(bc_sof_a), .bc_eof(bc_eof_a), .busy(busy_a)
    );

    // Instance B: one digit, no check digit, no gap
    logic        rst_b = 1'b1, in_valid_b = 1'b0, out_ready_b = 1'b0;
    logic [3:0]  in_num_b = '0;
    logic        in_ready_b, bc_valid_b, bc_bit_b, bc_sof_b, bc_eof_b, busy_b;

    bc_frame_serializer #(.DIGITS(1), .CHECK_EN(0), .GAP(0)) dut_b (
        .clk(clk), .rst(rst_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .in_num(in_num_b), .out_ready(out_ready_b), .bc_valid(bc_valid_b),
        .bc_bit(bc_bit_b), .bc_sof(bc_sof_b), .bc_eof(bc_eof_b), .busy(busy_b)
    );

    typedef bit bitq_t[$];

    // Reference frame: guard, one code per digit (plus check), guard.
    function automatic bitq_t ref_frame(input logic [63:0] num, input int digits, input int chk);
        bitq_t q;
        int    sum;
        int    d;
        sum = 0;
        q.push_back(1'b1); q.push_back(1'b0); q.push_back(1'b1);
        for (int i = 0; i < digits + chk; i++) begin
            if (i < digits) begin
                d   = int'((num >> (4 * (digits - 1 - i))) & 64'hF);
                sum = sum + d;
            end else begin
                d = sum % 16;
            end
            q.push_back(1'b1); q.push_back(1'b0);
            for (int b = 3; b >= 0; b--) begin
                q.push_back(d[b]);
                q.push_back(!d[b]);
            end
            q.push_back(1'b0);
        end
        q.push_back(1'b1); q.push_back(1'b0); q.push_back(1'b1);
        return q;
    endfunction

    // Number of differing positions, including any difference in length.
    function automatic int count_diff(input bitq_t a, input bitq_t b);
        int n;
        int m;
        n = (a.size() > b.size()) ? a.size() - b.size() : b.size() - a.size();
        m = (a.size() < b.size()) ? a.size() : b.size();
        for (int i = 0; i < m; i++) if (a[i] != b[i]) n++;
        return n;
    endfunction

    // Capture of one frame from instance A
    bitq_t cap_bits;
    int    sof_pos[$];
    int    eof_pos[$];
    int    stab_errs;
    bit    timed_out;

    task automatic collect_a(input bit random_bp, input bit scramble);
        bit         done;
        bit         held;
        logic [3:0] held_v;
        done = 0; held = 0; held_v = '0;
        cap_bits.delete(); sof_pos.delete(); eof_pos.delete();
        stab_errs = 0; timed_out = 1;
        for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
            @(negedge clk);
            if (held && ({bc_valid_a, bc_bit_a, bc_sof_a, bc_eof_a} !== held_v)) stab_errs++;
            held = 0;
            if (bc_valid_a) begin
                if (out_ready_a) begin
                    if (bc_sof_a) sof_pos.push_back(cap_bits.size());
                    if (bc_eof_a) begin
                        eof_pos.push_back(cap_bits.size());
                        done = 1;
                        timed_out = 0;
                    end
                    cap_bits.push_back(bc_bit_a);
                end else begin
                    held   = 1;
                    held_v = {bc_valid_a, bc_bit_a, bc_sof_a, bc_eof_a};
                end
            end
            @(posedge clk); #1;
            out_ready_a = random_bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (scramble) begin
                in_valid_a = 1'($urandom_range(0, 1));
                in_num_a   = 16'($urandom);
            end
        end
        in_valid_a  = 1'b0;
        out_ready_a = 1'b1;
    endtask

    task automatic send_a(input logic [15:0] num);
        @(posedge clk); #1;
        in_num_a   = num;
        in_valid_a = 1'b1;
        @(posedge clk); #1;
        in_valid_a = 1'b0;
    endtask

    task automatic wait_idle_a();
        bit seen;
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (in_ready_a === 1'b1) seen = 1;
        end
        total_cnt++;
        if (!seen) $display("FAIL idle_wait: got in_ready=0 for 200 cycles, required in_ready=1");
        else pass_cnt++;
    endtask

    task automatic test_reset();
        rst_a = 1'b1; rst_b = 1'b1;
        in_valid_a = 1'b1; in_valid_b = 1'b1; out_ready_a = 1'b1; out_ready_b = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total_cnt++;
            if ({bc_valid_a, bc_bit_a, bc_sof_a, bc_eof_a, busy_a, in_ready_a,
                 bc_valid_b, bc_bit_b, bc_sof_b, bc_eof_b, busy_b, in_ready_b} !== 12'b0)
                $display("FAIL reset_outputs: got A=%b B=%b required all 0",
                         {bc_valid_a, bc_bit_a, bc_sof_a, bc_eof_a, busy_a, in_ready_a},
                         {bc_valid_b, bc_bit_b, bc_sof_b, bc_eof_b, busy_b, in_ready_b});
            else pass_cnt++;
        end
        @(posedge clk); #1;
        in_valid_a = 1'b0; in_valid_b = 1'b0;
        rst_a = 1'b0; rst_b = 1'b0;
        @(negedge clk);
        total_cnt++;
        if ({in_ready_a, busy_a, in_ready_b, busy_b} !== 4'b1010)
            $display("FAIL reset_release: got ready/busy A=%b%b B=%b%b required 10 10",
                     in_ready_a, busy_a, in_ready_b, busy_b);
        else pass_cnt++;
        $display("reset: released, in_ready_a=%b in_ready_b=%b", in_ready_a, in_ready_b);
    endtask

    task automatic test_defaults();
        logic [60:0] golden;
        bitq_t       gq;
        int          errs;
        golden = 61'b101_10010101010_10011001100_10100110010_10101010100_10101010010_101;
        for (int i = 0; i < 61; i++) gq.push_back(golden[60 - i]);
        out_ready_a = 1'b1;
        send_a(16'h05AF);
        collect_a(1'b0, 1'b0);
        total_cnt++;
        if (timed_out) $display("FAIL dflt_done: got no eof within budget, required eof");
        else pass_cnt++;
        total_cnt++;
        if (cap_bits.size() != 61) $display("FAIL dflt_len: got %0d bars required 61", cap_bits.size());
        else pass_cnt++;
        errs = count_diff(cap_bits, gq);
        total_cnt++;
        if (errs != 0) $display("FAIL dflt_bars: got %0d wrong bars required 0", errs);
        else pass_cnt++;
        total_cnt++;
        if (sof_pos.size() != 1 || sof_pos[0] != 0)
            $display("FAIL dflt_sof: got %0d sof pulses (first at %0d) required 1 at bar 0",
                     sof_pos.size(), (sof_pos.size() > 0) ? sof_pos[0] : -1);
        else pass_cnt++;
        total_cnt++;
        if (eof_pos.size() != 1 || eof_pos[0] != 60)
            $display("FAIL dflt_eof: got eof at bar %0d required 60",
                     (eof_pos.size() > 0) ? eof_pos[0] : -1);
        else pass_cnt++;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            total_cnt++;
            if ({bc_valid_a, bc_bit_a, in_ready_a, busy_a} !== 4'b0001)
                $display("FAIL dflt_gap: cycle %0d got valid/bit/ready/busy=%b required 0001",
                         k, {bc_valid_a, bc_bit_a, in_ready_a, busy_a});
            else pass_cnt++;
        end
        @(negedge clk);
        total_cnt++;
        if ({in_ready_a, busy_a} !== 2'b10)
            $display("FAIL dflt_post_gap: got ready/busy=%b required 10", {in_ready_a, busy_a});
        else pass_cnt++;
        $display("frame A num=05af bars=%0d errs=%0d", cap_bits.size(), errs);
    endtask

    task automatic test_backpressure();
        bitq_t       exp;
        logic [15:0] num;
        int          errs;
        for (int f = 0; f < 7; f++) begin
            num = (f == 0) ? 16'h05AF : 16'($urandom);
            exp = ref_frame(64'(num), 4, 1);
            out_ready_a = 1'($urandom_range(0, 1));
            send_a(num);
            collect_a(1'b1, 1'b0);
            errs = count_diff(cap_bits, exp);
            total_cnt++;
            if (timed_out || errs != 0)
                $display("FAIL bp_frame: num=%h got %0d bars %0d wrong (timeout=%0d) required %0d bars 0 wrong",
                         num, cap_bits.size(), errs, timed_out, exp.size());
            else pass_cnt++;
            total_cnt++;
            if (stab_errs != 0) $display("FAIL bp_hold: num=%h got %0d unstable stalls required 0", num, stab_errs);
            else pass_cnt++;
            $display("frame A bp num=%h bars=%0d errs=%0d stalls_bad=%0d", num, cap_bits.size(), errs, stab_errs);
            wait_idle_a();
        end
    endtask

    task automatic test_back_to_back();
        logic [16:0] pat;
        int          errs;
        int          ph;
        logic        exp_valid;
        logic        exp_bit;
        int          sofs[$];
        int          eofs[$];
        pat  = 17'b101_10010101010_101;
        errs = 0;
        in_num_b = 4'h0; out_ready_b = 1'b1;
        @(posedge clk); #1;
        in_valid_b = 1'b1;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            exp_valid = 1'b0;
            exp_bit   = 1'b0;
            if (cyc >= 1) begin
                ph = (cyc - 1) % 18;
                if (ph < 17) begin
                    exp_valid = 1'b1;
                    exp_bit   = pat[16 - ph];
                end
            end
            if (bc_valid_b !== exp_valid || bc_bit_b !== exp_bit) errs++;
            if (bc_sof_b) sofs.push_back(cyc);
            if (bc_eof_b) eofs.push_back(cyc);
        end
        total_cnt++;
        if (errs != 0) $display("FAIL b2b_stream: got %0d wrong cycles required 0", errs);
        else pass_cnt++;
        total_cnt++;
        if (sofs.size() != 4 || sofs[0] != 1 || sofs[1] != 19 || sofs[2] != 37)
            $display("FAIL b2b_sof: got %0d sofs first at %0d required 4 at 1,19,37,55",
                     sofs.size(), (sofs.size() > 0) ? sofs[0] : -1);
        else pass_cnt++;
        total_cnt++;
        if (eofs.size() != 3 || eofs[0] != 17 || eofs[2] != 53)
            $display("FAIL b2b_eof: got %0d eofs first at %0d required 3 at 17,35,53",
                     eofs.size(), (eofs.size() > 0) ? eofs[0] : -1);
        else pass_cnt++;
        $display("b2b B: sofs=%0d eofs=%0d bad_cycles=%0d", sofs.size(), eofs.size(), errs);
        in_valid_b = 1'b0;
        begin
            bit seen;
            seen = 0;
            for (int i = 0; i < 100 && !seen; i++) begin
                @(negedge clk);
                if (in_ready_b === 1'b1) seen = 1;
            end
            total_cnt++;
            if (!seen) $display("FAIL b2b_idle: got in_ready_b=0 for 100 cycles required 1");
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_midframe();
        int          n;
        bit          leftover;
        bitq_t       exp;
        logic [15:0] num;
        int          errs;
        n = 0;
        out_ready_a = 1'b1;
        send_a(16'h05AF);
        for (int cyc = 0; cyc < 200 && n < 20; cyc++) begin
            @(negedge clk);
            if (bc_valid_a && out_ready_a) n++;
            @(posedge clk); #1;
        end
        rst_a = 1'b1;
        @(negedge clk);
        total_cnt++;
        if ({bc_valid_a, bc_bit_a, bc_sof_a, bc_eof_a, busy_a, in_ready_a} !== 6'b0)
            $display("FAIL mid_rst_outputs: after %0d bars got %b required 000000",
                     n, {bc_valid_a, bc_bit_a, bc_sof_a, bc_eof_a, busy_a, in_ready_a});
        else pass_cnt++;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_a = 1'b0;
        leftover = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bc_valid_a !== 1'b0 || in_ready_a !== 1'b1) leftover = 1;
        end
        total_cnt++;
        if (leftover) $display("FAIL mid_rst_leftover: got stray bars or in_ready low after release required idle");
        else pass_cnt++;
        num = 16'($urandom);
        exp = ref_frame(64'(num), 4, 1);
        send_a(num);
        collect_a(1'b0, 1'b0);
        errs = count_diff(cap_bits, exp);
        total_cnt++;
        if (timed_out || errs != 0 || sof_pos.size() != 1 || sof_pos[0] != 0)
            $display("FAIL mid_rst_new_frame: num=%h got %0d wrong bars sof_count=%0d required 0 wrong sof at 0",
                     num, errs, sof_pos.size());
        else pass_cnt++;
        $display("frame A after reset num=%h bars=%0d errs=%0d", num, cap_bits.size(), errs);
        wait_idle_a();
    endtask

    task automatic test_ignore_busy();
        bitq_t       exp;
        logic [15:0] num;
        int          errs;
        bit          extra;
        num = 16'($urandom);
        exp = ref_frame(64'(num), 4, 1);
        out_ready_a = 1'b1;
        send_a(num);
        collect_a(1'b1, 1'b1);
        errs = count_diff(cap_bits, exp);
        total_cnt++;
        if (timed_out || errs != 0)
            $display("FAIL busy_frame: num=%h got %0d wrong bars (timeout=%0d) required 0", num, errs, timed_out);
        else pass_cnt++;
        extra = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bc_valid_a !== 1'b0) extra = 1;
        end
        total_cnt++;
        if (extra || in_ready_a !== 1'b1)
            $display("FAIL busy_no_second: got extra_bars=%0d in_ready=%b required 0 and 1", extra, in_ready_a);
        else pass_cnt++;
        $display("frame A scrambled-input num=%h bars=%0d errs=%0d", num, cap_bits.size(), errs);
    endtask

    initial begin
        test_reset();
        test_defaults();
        wait_idle_a();
        test_backpressure();
        test_back_to_back();
        test_reset_midframe();
        test_ignore_busy();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
